inst_decode_pipe: RTL and testbench
===================================

Name: inst_decode_pipe

Overview:
Parametrised RV64I-subset decode stage with an integrated register file and a valid/ready output pipeline register. It sits between fetch and execute. It accepts one 32-bit instruction plus its PC per handshake and decodes OP, OP-IMM, LOAD, STORE, LUI and AUIPC. It reads operands, sign-extends immediates and raises control flags. Adds backpressure, flush, store and U-type support, illegal-opcode detection and XLEN generality.

Parameters:
XLEN, 64, datapath/register width (32 or 64)
REG_AW, 5, register address width; NREGS = 2**REG_AW (32 regs)

Ports:
CLK  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  fetch presents inst/pc
in_ready  out  1  stage can accept; = !out_valid || out_ready (combinational)
inst  in  32  instruction word
pc  in  XLEN  instruction address
flush  in  1  kill held/incoming instruction
wb_en  in  1  writeback strobe
wb_rd  in  REG_AW  writeback register
wb_value  in  XLEN  writeback data
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
rd, rs1, rs2  out  REG_AW each  register indices (0 when unused by format)
funct3  out  3  inst[14:12]
funct7  out  7  inst[31:25] for OP/OP-IMM, else 0
imm  out  XLEN  sign-extended immediate (0 for OP)
op1, op2  out  XLEN  ALU operands
store_data  out  XLEN  rs2 value for STORE, else 0
write_back, imm_flag, mem_acc, load_flag, store_flag, illegal  out  1 each  control flags

Behaviour:
- Reset (async, low): all registers x0..x(NREGS-1) = 0; all outputs, including out_valid, = 0. in_ready = 1 after reset.
- Register file write: at posedge, wb_en && wb_rd!=0 -> regs[wb_rd] <= wb_value. x0 always reads 0. Writes continue during flush and stall.
- Accept: in_valid && in_ready at posedge. Decoded bundle is registered and out_valid <= 1. Latency is 1 cycle.
- Hold: out_valid && !out_ready -> all outputs frozen. Operands are captured at accept and are not refreshed by later writebacks.
- Drain: out_ready && !accept -> out_valid <= 0. Outputs other than out_valid keep their last values.
- Flush: at posedge, out_valid <= 0 and input is not accepted. Flush has priority over accept and hold.
- Decode (I = sext(inst[31:20]), S = sext({inst[31:25],inst[11:7]}), U = sext({inst[31:12],12'b0})):
  OP 0110011: op1=R[rs1], op2=R[rs2], imm=0, write_back=1, other flags 0.
  OP-IMM 0010011: op1=R[rs1], op2=imm=I, rs2=0, imm_flag=1, write_back=1.
  LOAD 0000011: op1=R[rs1], op2=imm=I, funct3 preserved, rs2=0, mem_acc=1, load_flag=1, imm_flag=1, write_back=1.
  STORE 0100011: op1=R[rs1], op2=imm=S, store_data=R[rs2], rd=0, mem_acc=1, store_flag=1, imm_flag=1, write_back=0.
  LUI 0110111: op1=0, op2=imm=U, rs1=rs2=0, imm_flag=1, write_back=1.
  AUIPC 0010111: op1=pc, op2=imm=U, rs1=rs2=0, imm_flag=1, write_back=1.
  Other opcode: illegal=1, all other flags 0, rd=rs1=rs2=0, op1=op2=imm=0. out_valid still asserts so the exception can propagate.
- Flags are fully re-driven on every accept; nothing sticks from the prior instruction.
- Same-edge writeback and read of the same register (bypass disabled): the operand gets the OLD value.

Optional Feature:
DECODE_WB_BYPASS_EN: when defined, on accept with wb_en && wb_rd==rsN && rsN!=0, the operand (op1/op2/store_data) takes wb_value instead of the stale register. When undefined, the operand gets the old register value and the hazard is left to downstream forwarding.

Test Plan:
- Reset, then wb x5=0x10, then accept ADD x3,x5,x5 (0x005281B3) -> next cycle out_valid=1, op1=op2=0x10, rd=3, write_back=1, imm_flag=0.
- ADDI x1,x0,-1 (0xFFF00093) -> op1=0, op2=imm=0xFFFFFFFFFFFFFFFF, imm_flag=1, rs2=0.
- SD x6,8(x2) with x2=0x100, x6=0xAB (0x00613423) -> op1=0x100, op2=8, store_data=0xAB, store_flag=1, mem_acc=1, write_back=0, rd=0.
- AUIPC x4,0x1 at pc=0x8000 -> op1=0x8000, op2=0x1000, write_back=1. Then opcode 0x7F -> illegal=1, write_back=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. out_ready=1 -> next instruction accepted that edge. Flush asserted with in_valid=1 -> out_valid=0 next cycle.
- Same-cycle wb x7=0x55 and accept ADD x8,x7,x0 (x7 previously 0) -> op1=0 without the macro, op1=0x55 with DECODE_WB_BYPASS_EN. Write wb_rd=0 -> x0 stays 0.

Source files
------------

// File: rtl/inst_decode_pipe.sv
// RV64I-subset decode stage: register file, immediate/operand decode and a valid/ready output register.
// Optional macro DECODE_WB_BYPASS_EN forwards same-edge writeback data into the captured operands.
module inst_decode_pipe #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned REG_AW = 5
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   pc,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_value,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] rd,
    output logic [REG_AW-1:0] rs1,
    output logic [REG_AW-1:0] rs2,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2,
    output logic [XLEN-1:0]   store_data,
    output logic              write_back,
    output logic              imm_flag,
    output logic              mem_acc,
    output logic              load_flag,
    output logic              store_flag,
    output logic              illegal
);
    localparam int unsigned NREGS = 2 ** REG_AW;

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcAuipc = 7'b0010111;

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [REG_AW-1:0] f_rd, f_rs1, f_rs2;
    logic [XLEN-1:0]   rv1, rv2, imm_i, imm_s, imm_u;
    logic              accept;

    logic [REG_AW-1:0] rd_d, rs1_d, rs2_d, rd_q, rs1_q, rs2_q;
    logic [2:0]        funct3_d, funct3_q;
    logic [6:0]        funct7_d, funct7_q;
    logic [XLEN-1:0]   imm_d, op1_d, op2_d, sd_d, imm_q, op1_q, op2_q, sd_q;
    logic [5:0]        flags_d, flags_q; // {write_back, imm_flag, mem_acc, load, store, illegal}
    logic              out_valid_q;

    assign f_rd  = REG_AW'(inst[11:7]);
    assign f_rs1 = REG_AW'(inst[19:15]);
    assign f_rs2 = REG_AW'(inst[24:20]);

    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));

`ifdef DECODE_WB_BYPASS_EN
    assign rv1 = (f_rs1 == '0) ? '0 : (wb_en && wb_rd == f_rs1) ? wb_value : regs_q[f_rs1];
    assign rv2 = (f_rs2 == '0) ? '0 : (wb_en && wb_rd == f_rs2) ? wb_value : regs_q[f_rs2];
`else
    assign rv1 = (f_rs1 == '0) ? '0 : regs_q[f_rs1];
    assign rv2 = (f_rs2 == '0) ? '0 : regs_q[f_rs2];
`endif

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // x0 is never written, so it stays at its reset value of zero
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_en && wb_rd != '0) begin
            regs_q[wb_rd] <= wb_value;
        end
    end

    always_comb begin
        rd_d     = '0;
        rs1_d    = '0;
        rs2_d    = '0;
        funct3_d = inst[14:12];
        funct7_d = '0;
        imm_d    = '0;
        op1_d    = '0;
        op2_d    = '0;
        sd_d     = '0;
        flags_d  = 6'b000000;
        case (inst[6:0])
            OpcOp: begin
                rd_d = f_rd; rs1_d = f_rs1; rs2_d = f_rs2; funct7_d = inst[31:25];
                op1_d = rv1; op2_d = rv2; flags_d = 6'b100000;
            end
            OpcOpImm: begin
                rd_d = f_rd; rs1_d = f_rs1; funct7_d = inst[31:25];
                op1_d = rv1; op2_d = imm_i; imm_d = imm_i; flags_d = 6'b110000;
            end
            OpcLoad: begin
                rd_d = f_rd; rs1_d = f_rs1;
                op1_d = rv1; op2_d = imm_i; imm_d = imm_i; flags_d = 6'b111100;
            end
            OpcStore: begin
                rs1_d = f_rs1; rs2_d = f_rs2; sd_d = rv2;
                op1_d = rv1; op2_d = imm_s; imm_d = imm_s; flags_d = 6'b011010;
            end
            OpcLui: begin
                rd_d = f_rd; op2_d = imm_u; imm_d = imm_u; flags_d = 6'b110000;
            end
            OpcAuipc: begin
                rd_d = f_rd; op1_d = pc; op2_d = imm_u; imm_d = imm_u; flags_d = 6'b110000;
            end
            default: flags_d = 6'b000001;
        endcase
    end

    // Flush wins over accept and hold; the bundle only changes on accept
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            imm_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            sd_q        <= '0;
            flags_q     <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            funct3_q    <= funct3_d;
            funct7_q    <= funct7_d;
            imm_q       <= imm_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            sd_q        <= sd_d;
            flags_q     <= flags_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign rd         = rd_q;
    assign rs1        = rs1_q;
    assign rs2        = rs2_q;
    assign funct3     = funct3_q;
    assign funct7     = funct7_q;
    assign imm        = imm_q;
    assign op1        = op1_q;
    assign op2        = op2_q;
    assign store_data = sd_q;
    assign write_back = flags_q[5];
    assign imm_flag   = flags_q[4];
    assign mem_acc    = flags_q[3];
    assign load_flag  = flags_q[2];
    assign store_flag = flags_q[1];
    assign illegal    = flags_q[0];

endmodule

// File: tb/tb_inst_decode_pipe.sv
// Self-checking bench for inst_decode_pipe: directed vector table, hand sequences and random traffic
// checked against a transaction-level model.
module tb_inst_decode_pipe;
    logic        CLK = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic [31:0] inst;
    logic [63:0] pc, wb_value, imm, op1, op2, store_data;
    logic [4:0]  wb_rd, rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        write_back, imm_flag, mem_acc, load_flag, store_flag, illegal;

    inst_decode_pipe #(.XLEN(64), .REG_AW(5)) dut (
        .CLK(CLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
        .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_value(wb_value), .out_valid(out_valid),
        .out_ready(out_ready), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .op1(op1), .op2(op2), .store_data(store_data), .write_back(write_back),
        .imm_flag(imm_flag), .mem_acc(mem_acc), .load_flag(load_flag), .store_flag(store_flag),
        .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [63:0] imm, op1, op2, sd;
        logic [5:0]  flags;
    } bundle_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc, op1, op2, imm, sd;
        logic [4:0]  rd;
        logic [5:0]  flags;
    } vec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] m_regs [32];
    bundle_t     m_b;
    logic        m_valid;
    bundle_t     saved;
    vec_t        vecs [7];

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bundle_t dut_bundle();
        bundle_t b;
        b = '{rd, rs1, rs2, funct3, funct7, imm, op1, op2, store_data,
              {write_back, imm_flag, mem_acc, load_flag, store_flag, illegal}};
        return b;
    endfunction

    function automatic logic [63:0] rreg(input logic [4:0] idx);
        if (idx == 0) return 64'd0;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && wb_rd == idx) return wb_value;
`endif
        return m_regs[idx];
    endfunction

    // Reference decode straight from the ISA field definitions
    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [63:0] p);
        bundle_t     b;
        logic [11:0] ii, ss;
        logic [31:0] uu;
        logic [63:0] iv, sv, uv;
        ii = w[31:20];
        ss = {w[31:25], w[11:7]};
        uu = {w[31:12], 12'h000};
        iv = 64'($signed(ii));
        sv = 64'($signed(ss));
        uv = 64'($signed(uu));
        b = '0;
        b.funct3 = w[14:12];
        case (w[6:0])
            7'h33: b = '{w[11:7], w[19:15], w[24:20], w[14:12], w[31:25], 64'd0,
                         rreg(w[19:15]), rreg(w[24:20]), 64'd0, 6'b100000};
            7'h13: b = '{w[11:7], w[19:15], 5'd0, w[14:12], w[31:25], iv,
                         rreg(w[19:15]), iv, 64'd0, 6'b110000};
            7'h03: b = '{w[11:7], w[19:15], 5'd0, w[14:12], 7'd0, iv,
                         rreg(w[19:15]), iv, 64'd0, 6'b111100};
            7'h23: b = '{5'd0, w[19:15], w[24:20], w[14:12], 7'd0, sv,
                         rreg(w[19:15]), sv, rreg(w[24:20]), 6'b011010};
            7'h37: b = '{w[11:7], 5'd0, 5'd0, w[14:12], 7'd0, uv, 64'd0, uv, 64'd0, 6'b110000};
            7'h17: b = '{w[11:7], 5'd0, 5'd0, w[14:12], 7'd0, uv, p, uv, 64'd0, 6'b110000};
            default: b.flags = 6'b000001;
        endcase
        return b;
    endfunction

    // One clock: predict from current inputs, advance, compare the whole visible state
    task automatic tick();
        bundle_t nb;
        logic    nv;
        nb = m_b;
        nv = m_valid;
        if (flush) nv = 1'b0;
        else if (in_valid && (!m_valid || out_ready)) begin
            nb = ref_decode(inst, pc);
            nv = 1'b1;
        end else if (out_ready) nv = 1'b0;
        if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_value;
        @(posedge CLK);
        #1;
        m_b = nb;
        m_valid = nv;
        chk("out_valid", 320'(out_valid), 320'(nv));
        chk("bundle", 320'(dut_bundle()), 320'(nb));
        chk("in_ready", 320'(in_ready), 320'(!nv || out_ready));
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; wb_en = 0; out_ready = 1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [63:0] v);
        wb_en = 1; wb_rd = r; wb_value = v;
        tick();
        wb_en = 0;
    endtask

    task automatic issue(input logic [31:0] w, input logic [63:0] p);
        in_valid = 1; inst = w; pc = p;
        tick();
        in_valid = 0;
    endtask

    initial begin
        //          inst          pc       op1       op2                    imm                    sd       rd     flags
        vecs[0] = '{32'h005281B3, 64'h0,    64'h10,   64'h10,                64'h0,                 64'h0,   5'd3,  6'b100000};
        vecs[1] = '{32'hFFF00093, 64'h0,    64'h0,    64'hFFFFFFFFFFFFFFFF,  64'hFFFFFFFFFFFFFFFF,  64'h0,   5'd1,  6'b110000};
        vecs[2] = '{32'h00613423, 64'h0,    64'h100,  64'h8,                 64'h8,                 64'hAB,  5'd0,  6'b011010};
        vecs[3] = '{32'h00001217, 64'h8000, 64'h8000, 64'h1000,              64'h1000,              64'h0,   5'd4,  6'b110000};
        vecs[4] = '{32'h0000007F, 64'h8004, 64'h0,    64'h0,                 64'h0,                 64'h0,   5'd0,  6'b000001};
        vecs[5] = '{32'hFF013483, 64'h0,    64'h100,  64'hFFFFFFFFFFFFFFF0,  64'hFFFFFFFFFFFFFFF0,  64'h0,   5'd9,  6'b111100};
        vecs[6] = '{32'h80000537, 64'h0,    64'h0,    64'hFFFFFFFF80000000,  64'hFFFFFFFF80000000,  64'h0,   5'd10, 6'b110000};

        idle();
        inst = 0; pc = 0; wb_rd = 0; wb_value = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_b = '0;
        m_valid = 0;
        reset = 0;
        #23;
        reset = 1;
        #1;
        chk("reset out_valid", 320'(out_valid), 320'(0));
        chk("reset in_ready", 320'(in_ready), 320'(1));
        chk("reset bundle", 320'(dut_bundle()), 320'(0));

        wb(5'd5, 64'h10);
        wb(5'd2, 64'h100);
        wb(5'd6, 64'hAB);

        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].inst, vecs[i].pc);
            chk($sformatf("vec%0d valid", i), 320'(out_valid), 320'(1));
            chk($sformatf("vec%0d fields", i),
                320'({op1, op2, imm, store_data, rd,
                      write_back, imm_flag, mem_acc, load_flag, store_flag, illegal}),
                320'({vecs[i].op1, vecs[i].op2, vecs[i].imm, vecs[i].sd, vecs[i].rd,
                      vecs[i].flags}));
        end

        // Drain keeps the bundle but drops valid
        tick();
        chk("drain valid", 320'(out_valid), 320'(0));
        chk("drain rd kept", 320'(rd), 320'(10));

        // Backpressure: hold for three cycles, then accept on release, then flush
        issue(32'h005281B3, 64'h0);
        saved = dut_bundle();
        in_valid = 1; inst = 32'hFFF00093; out_ready = 0;
        #1;
        chk("stall in_ready", 320'(in_ready), 320'(0));
        for (int i = 0; i < 3; i++) begin
            wb(5'd5, 64'h77 + 64'(i));
            in_valid = 1;
            chk("hold bundle", 320'(dut_bundle()), 320'(saved));
            chk("hold valid", 320'(out_valid), 320'(1));
        end
        out_ready = 1;
        #1;
        chk("release in_ready", 320'(in_ready), 320'(1));
        tick();
        chk("release accept rd", 320'(rd), 320'(1));
        flush = 1; inst = 32'h005281B3;
        tick();
        chk("flush valid", 320'(out_valid), 320'(0));
        idle();

        // Same-edge writeback vs operand read, and x0 immunity
        wb_en = 1; wb_rd = 5'd7; wb_value = 64'h55;
        issue(32'h00038433, 64'h0);
        wb_en = 0;
`ifdef DECODE_WB_BYPASS_EN
        chk("same-edge op1", 320'(op1), 320'(64'h55));
`else
        chk("same-edge op1", 320'(op1), 320'(64'h0));
`endif
        issue(32'h00038433, 64'h0);
        chk("x7 after wb", 320'(op1), 320'(64'h55));
        wb(5'd0, 64'hDEAD);
        issue(32'h00000433, 64'h0);
        chk("x0 stays 0", 320'({op1, op2}), 320'(128'h0));

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [6:0] opc;
            case ($urandom_range(0, 6))
                0: opc = 7'h33;
                1: opc = 7'h13;
                2: opc = 7'h03;
                3: opc = 7'h23;
                4: opc = 7'h37;
                5: opc = 7'h17;
                default: opc = 7'($urandom);
            endcase
            inst      = {25'($urandom), opc};
            pc        = {$urandom, $urandom};
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            wb_en     = ($urandom_range(0, 1) != 0);
            wb_rd     = 5'($urandom);
            wb_value  = {$urandom, $urandom};
            tick();
        end
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
